// File: rtl/frame_buf_pkg.sv
// Shared definitions for the frame-buffer arbiter: requester indices,
// FSM state encoding and the arbitration helper functions.
package frame_buf_pkg;

    localparam int N_REQ  = 3;
    localparam int REQ_DS = 0;   // down-sampler write
    localparam int REQ_US = 1;   // up-sampler read
    localparam int REQ_RO = 2;   // display/readout read

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // One-hot vector for a requester index; index 3 never occurs.
    function automatic logic [N_REQ-1:0] req_onehot(input logic [1:0] idx);
        logic [N_REQ-1:0] oh;
        oh = '0;
        case (idx)
            2'(REQ_DS): oh = 3'b001;
            2'(REQ_US): oh = 3'b010;
            2'(REQ_RO): oh = 3'b100;
            default:    oh = '0;
        endcase
        return oh;
    endfunction

    // Index following idx in the ring 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] ring_next(input logic [1:0] idx);
        return (idx == 2'(REQ_RO)) ? 2'(REQ_DS) : idx + 2'd1;
    endfunction

    // Round-robin pick: first requester with req set, searching
    // owner+1, owner+2, owner. Returns owner when nobody requests.
    function automatic logic [1:0] next_rr(input logic [1:0] owner,
                                           input logic [N_REQ-1:0] req);
        logic [1:0] c1;
        logic [1:0] c2;
        logic [1:0] pick;
        c1   = ring_next(owner);
        c2   = ring_next(c1);
        pick = owner;
        if (req[c1])         pick = c1;
        else if (req[c2])    pick = c2;
        else                 pick = owner;
        return pick;
    endfunction

    // Fixed-priority pick: 0 > 1 > 2.
    function automatic logic [1:0] fixed_prio(input logic [N_REQ-1:0] req);
        logic [1:0] pick;
        if (req[REQ_DS])      pick = 2'(REQ_DS);
        else if (req[REQ_US]) pick = 2'(REQ_US);
        else                  pick = 2'(REQ_RO);
        return pick;
    endfunction

endpackage

// File: rtl/frame_buf_rd_tag.sv
// Read-return tag pipeline: an RD_LAT-deep shift register of
// {valid, owner} that lines up with the BRAM read latency and produces
// the per-requester read-valid. Synchronous clear drops reads in flight.
module frame_buf_rd_tag
    import frame_buf_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [1:0]       push_owner,
    output logic [N_REQ-1:0] rvalid
);

    logic [RD_LAT-1:0] vld;
    logic [1:0]        tag [RD_LAT];

    // Shift {valid, owner} one stage per cycle; reset empties the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag[i] <= 2'd0;
            end
        end else begin
            vld[0] <= push;
            tag[0] <= push_owner;
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
                tag[i] <= tag[i-1];
            end
        end
    end

    // Decode the oldest stage into a one-hot read-valid.
    always_comb begin
        rvalid = '0;
        if (vld[RD_LAT-1]) begin
            rvalid = req_onehot(tag[RD_LAT-1]);
        end
    end

endmodule

// File: rtl/frame_buf_arbiter.sv
// Frame-buffer BRAM arbiter: grants whole bursts to one of three
// requesters (DS write, US read, RO read), muxes the owner onto the
// single RAM port and routes read data back with a per-requester valid.
// Handshake: a beat transfers in any cycle where gnt_o[k] & req_i[k];
// the requester holds addr/we/wdata/last stable until that cycle.
// Build option ARB_FIXED_PRIO_EN: when defined, idle selection is fixed
// priority 0 > 1 > 2 instead of round-robin.
module frame_buf_arbiter
    import frame_buf_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16,
    parameter int RD_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_i,
    input  logic [N_REQ-1:0]      we_i,
    input  logic [N_REQ-1:0]      last_i,
    input  logic [3*ADDR_W-1:0]   addr_i,
    input  logic [3*DATA_W-1:0]   wdata_i,
    output logic [N_REQ-1:0]      gnt_o,
    output logic [N_REQ-1:0]      rvalid_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  busy_o,
    output logic [1:0]            owner_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t             state, state_n;
    logic [1:0]         owner, owner_n;
    logic [N_REQ-1:0]   gnt, gnt_n;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_n;
    logic [CNT_W-1:0]   beat_inc;
    logic [1:0]         pick;

    logic               own_req;
    logic               own_we;
    logic               own_last;
    logic               own_gnt;
    logic               accept;

`ifdef ARB_FIXED_PRIO_EN
    assign pick = fixed_prio(req_i);
`else
    assign pick = next_rr(owner, req_i);
`endif

    // Select the owner's request controls and RAM-side address/data.
    always_comb begin
        own_req     = req_i[REQ_RO];
        own_we      = we_i[REQ_RO];
        own_last    = last_i[REQ_RO];
        own_gnt     = gnt[REQ_RO];
        mem_addr_o  = addr_i[REQ_RO*ADDR_W +: ADDR_W];
        mem_wdata_o = wdata_i[REQ_RO*DATA_W +: DATA_W];
        case (owner)
            2'(REQ_DS): begin
                own_req     = req_i[REQ_DS];
                own_we      = we_i[REQ_DS];
                own_last    = last_i[REQ_DS];
                own_gnt     = gnt[REQ_DS];
                mem_addr_o  = addr_i[REQ_DS*ADDR_W +: ADDR_W];
                mem_wdata_o = wdata_i[REQ_DS*DATA_W +: DATA_W];
            end
            2'(REQ_US): begin
                own_req     = req_i[REQ_US];
                own_we      = we_i[REQ_US];
                own_last    = last_i[REQ_US];
                own_gnt     = gnt[REQ_US];
                mem_addr_o  = addr_i[REQ_US*ADDR_W +: ADDR_W];
                mem_wdata_o = wdata_i[REQ_US*DATA_W +: DATA_W];
            end
            default: begin
            end
        endcase
    end

    assign accept   = own_req & own_gnt;
    assign beat_inc = beat_cnt + CNT_W'(1);
    assign mem_en_o = accept;
    assign mem_we_o = accept & own_we;

    // State, owner, grant and beat counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            owner    <= 2'(REQ_RO);
            gnt      <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            gnt      <= gnt_n;
            beat_cnt <= beat_cnt_n;
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats and detect burst end in BURST.
    always_comb begin
        state_n    = state;
        owner_n    = owner;
        gnt_n      = gnt;
        beat_cnt_n = beat_cnt;
        case (state)
            ST_IDLE: begin
                if (|req_i) begin
                    owner_n    = pick;
                    gnt_n      = req_onehot(pick);
                    beat_cnt_n = '0;
                    state_n    = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!own_req) begin
                    // Requester withdrew: release without a beat.
                    state_n = ST_IDLE;
                    gnt_n   = '0;
                end else if (accept) begin
                    beat_cnt_n = beat_inc;
                    if (own_last || (beat_inc == CNT_W'(MAX_BURST))) begin
                        state_n = ST_IDLE;
                        gnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    frame_buf_rd_tag #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag (
        .clk        (clk),
        .rst        (rst),
        .push       (accept & ~own_we),
        .push_owner (owner),
        .rvalid     (rvalid_o)
    );

    assign gnt_o   = gnt;
    assign owner_o = owner;
    assign busy_o  = (state == ST_BURST);
    assign rdata_o = mem_rdata_i;

endmodule
